// File: rtl/fsm_stim_checker.sv
// Stimulus generator and checker for a 5-state Mealy FSM: resets the target, drives a bit pattern, compares y_in against a golden model.
// Optional macro FSM_CHK_STOP_ON_ERR_EN ends a run at the first mismatch.
module fsm_stim_checker (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pattern,
  input  logic [3:0]  len,
  output logic        dut_rst,
  output logic        x_out,
  input  logic        y_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx
);

  localparam int unsigned PAT_W = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned ERR_W = 5;
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(16);

  localparam logic [2:0] M_A = 3'b000;
  localparam logic [2:0] M_B = 3'b001;
  localparam logic [2:0] M_C = 3'b010;
  localparam logic [2:0] M_D = 3'b011;
  localparam logic [2:0] M_E = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [IDX_W-1:0] r_len;
  logic [IDX_W-1:0] r_idx;
  logic [2:0]       r_m_st;
  logic             r_dut_rst;
  logic             r_x;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [IDX_W-1:0] r_first;

  logic             w_bit;
  logic             w_y_exp;
  logic [2:0]       w_m_next;
  logic             w_mis;
  logic             w_end;
  logic [ERR_W-1:0] w_err_nxt;

  // Golden Mealy model: expected y and next state for the bit being applied
  always_comb begin
    w_bit    = r_pat[r_idx];
    w_y_exp  = 1'b0;
    w_m_next = M_B;
    case (r_m_st)
      M_A:     begin w_y_exp = w_bit;  w_m_next = w_bit ? M_E : M_B; end
      M_B:     begin w_y_exp = w_bit;  w_m_next = w_bit ? M_E : M_B; end
      M_C:     begin w_y_exp = w_bit;  w_m_next = w_bit ? M_A : M_B; end
      M_D:     begin w_y_exp = 1'b1;   w_m_next = w_bit ? M_C : M_B; end
      M_E:     begin w_y_exp = ~w_bit; w_m_next = w_bit ? M_D : M_B; end
      default: begin w_y_exp = 1'b0;   w_m_next = M_B; end
    endcase
  end

  always_comb begin
    w_mis     = (y_in != w_y_exp);
    w_err_nxt = r_err + ERR_W'(w_mis && (r_err != ERR_MAX));
`ifdef FSM_CHK_STOP_ON_ERR_EN
    w_end     = (r_idx == r_len) || w_mis;
`else
    w_end     = (r_idx == r_len);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_m_st    <= M_B;
      r_dut_rst <= 1'b0;
      r_x       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_first   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_pat     <= pattern;
            r_len     <= len;
            r_err     <= '0;
            r_first   <= '0;
            r_pass    <= 1'b0;
            r_dut_rst <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_RST;
          end
        end
        S_RST: begin
          r_dut_rst <= 1'b0;
          r_m_st    <= M_B;
          r_idx     <= '0;
          r_x       <= r_pat[0];
          r_state   <= S_RUN;
        end
        S_RUN: begin
          r_m_st <= w_m_next;
          r_err  <= w_err_nxt;
          if (w_mis && (r_err == '0)) begin
            r_first <= r_idx;
          end
          if (w_end) begin
            r_x     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
            r_x   <= r_pat[IDX_W'(r_idx + IDX_W'(1))];
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_rst       = r_dut_rst;
  assign x_out         = r_x;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err;
  assign first_err_idx = r_first;

endmodule

// File: tb/tb_fsm_stim_checker.sv
// Bench for fsm_stim_checker: behavioural target FSM with fault injection, vector table, corner sequences and random runs.
module tb_fsm_stim_checker;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] pattern;
  logic [3:0]  len;
  logic        dut_rst, x_out, y_in, busy, done, pass;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;

  int total = 0;
  int bad   = 0;

  logic        yzero = 1'b0;
  logic [15:0] fmask = 16'h0;
  int          m_st  = 1;
  int          m_idx = 0;
  logic        y_good;

  fsm_stim_checker u_dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .dut_rst(dut_rst), .x_out(x_out), .y_in(y_in), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  // Target FSM transition table; states numbered A=0 .. E=4
  function automatic logic f_y(input int s, input logic x);
    case (s)
      0, 1, 2: return x;
      3:       return 1'b1;
      4:       return ~x;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int f_n(input int s, input logic x);
    case (s)
      0, 1:    return x ? 4 : 1;
      2:       return x ? 0 : 1;
      3:       return x ? 2 : 1;
      4:       return x ? 3 : 1;
      default: return 1;
    endcase
  endfunction

  // Behavioural FSM under test; fmask flips its output on chosen bit indices
  always_comb begin
    y_good = f_y(m_st, x_out);
    if (yzero) y_in = 1'b0;
    else       y_in = y_good ^ (busy && (m_idx < 16) && fmask[m_idx[3:0]]);
  end

  always @(posedge clk) begin
    if (dut_rst) begin
      m_st  <= 1;
      m_idx <= 0;
    end else begin
      m_st  <= f_n(m_st, x_out);
      m_idx <= m_idx + 1;
    end
  end

  // Reference: walk the bits, count disagreements; cyc is the cycle done appears (start cycle = 0)
  function automatic void model(input logic [15:0] p, input int n_len, input logic yz,
                                input logic [15:0] mk, output int err, output int first,
                                output int cyc);
    int   s;
    logic yg, ys;
    s = 1; err = 0; first = 0; cyc = 2;
    for (int i = 0; i <= n_len; i++) begin
      yg = f_y(s, p[i]);
      ys = yz ? 1'b0 : (yg ^ mk[i]);
      cyc++;
      if (ys != yg) begin
        if (err == 0) first = i;
        if (err < 16) err++;
`ifdef FSM_CHK_STOP_ON_ERR_EN
        break;
`endif
      end
      s = f_n(s, p[i]);
    end
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic [15:0] p, input logic [3:0] l,
                         input logic yz, input logic [15:0] mk, input int e_err,
                         input int e_first, input int e_pass, input int e_cyc, input int inj);
    int cyc;
    bit seen;
    @(negedge clk);
    pattern = p; len = l; yzero = yz; fmask = mk; start = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == inj) begin
        start = 1'b1; pattern = ~p; len = ~l;
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) begin
        chk({tag, " rst_dut_rst"}, int'(dut_rst), 1);
        chk({tag, " rst_busy"}, int'(busy), 1);
        chk({tag, " rst_x"}, int'(x_out), 0);
        chk({tag, " rst_err_clr"}, int'(err_count), 0);
        chk({tag, " rst_pass_clr"}, int'(pass), 0);
        chk({tag, " rst_first_clr"}, int'(first_err_idx), 0);
      end else if (done) begin
        seen = 1;
        chk({tag, " done_cycle"}, cyc, e_cyc);
        chk({tag, " done_busy"}, int'(busy), 0);
        chk({tag, " done_x"}, int'(x_out), 0);
        chk({tag, " err_count"}, int'(err_count), e_err);
        chk({tag, " first_err_idx"}, int'(first_err_idx), e_first);
        chk({tag, " pass"}, int'(pass), e_pass);
      end else if (cyc - 2 > 15) begin
        chk({tag, " overrun"}, cyc, e_cyc);
      end else begin
        chk({tag, " run_x"}, int'(x_out), int'(p[cyc-2]));
        chk({tag, " run_busy"}, int'(busy), 1);
        chk({tag, " run_dut_rst"}, int'(dut_rst), 0);
      end
    end
    start = 1'b0;
    if (!seen) chk({tag, " done_timeout"}, 0, 1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, int'(done), 0);
    chk({tag, " hold_err"}, int'(err_count), e_err);
    chk({tag, " hold_pass"}, int'(pass), e_pass);
  endtask

  typedef struct {
    logic [15:0] p;
    logic [3:0]  l;
    logic        yz;
    logic [15:0] mk;
    int          e_err, e_first, e_pass, e_cyc;
  } vec_t;

  vec_t vt[8];

  initial begin
    int e_err, e_first, e_pass, e_cyc;
    bit saw_done;
    logic [15:0] rp, rm;
    logic [3:0]  rl;
    logic        ryz;

    // Expected results for a run-to-completion build
    vt[0] = '{16'h003E, 4'd5,  1'b0, 16'h0000, 0,  0,  1, 8};
    vt[1] = '{16'h003E, 4'd5,  1'b1, 16'h0000, 4,  1,  0, 8};
    vt[2] = '{16'hFFFF, 4'd15, 1'b0, 16'h0000, 0,  0,  1, 18};
    vt[3] = '{16'h0000, 4'd0,  1'b0, 16'h0000, 0,  0,  1, 3};
    vt[4] = '{16'h0000, 4'd0,  1'b1, 16'h0000, 0,  0,  1, 3};
    vt[5] = '{16'hFFFF, 4'd15, 1'b0, 16'hFFFF, 16, 0,  0, 18};
    vt[6] = '{16'h1234, 4'd7,  1'b0, 16'h0180, 1,  7,  0, 10};
    vt[7] = '{16'hA5A5, 4'd15, 1'b0, 16'h8000, 1,  15, 0, 18};

    reset = 1'b1; start = 1'b0; pattern = 16'h0; len = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_dut_rst", int'(dut_rst), 0);
    chk("reset_x_out", int'(x_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pass", int'(pass), 0);
    chk("reset_err_count", int'(err_count), 0);
    chk("reset_first_err_idx", int'(first_err_idx), 0);
    reset = 1'b0;

    foreach (vt[k]) begin
      e_err = vt[k].e_err; e_first = vt[k].e_first; e_pass = vt[k].e_pass; e_cyc = vt[k].e_cyc;
`ifdef FSM_CHK_STOP_ON_ERR_EN
      if (e_err > 0) begin
        e_err = 1;
        e_cyc = e_first + 3;
      end
`endif
      run_one($sformatf("vec%0d", k), vt[k].p, vt[k].l, vt[k].yz, vt[k].mk,
              e_err, e_first, e_pass, e_cyc, 0);
    end

    // Start re-pulsed during RST and RUN with a different pattern must be ignored
    model(16'h003E, 5, 1'b1, 16'h0, e_err, e_first, e_cyc);
    run_one("ign_run", 16'h003E, 4'd5, 1'b1, 16'h0, e_err, e_first, 0, e_cyc, 3);
    run_one("ign_rst", 16'h003E, 4'd5, 1'b1, 16'h0, e_err, e_first, 0, e_cyc, 1);

    // Reset in RUN cycle 3 aborts the run without a done pulse
    @(negedge clk);
    pattern = 16'h003E; len = 4'd5; yzero = 1'b0; fmask = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_dut_rst", int'(dut_rst), 0);
    chk("abort_x_out", int'(x_out), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_err_count", int'(err_count), 0);
    chk("abort_first_err_idx", int'(first_err_idx), 0);
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    chk("abort_no_done", int'(saw_done), 0);

    // Reset wins over start in the same cycle
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_prio_busy", int'(busy), 0);
    chk("rst_prio_dut_rst", int'(dut_rst), 0);
    @(negedge clk);
    chk("rst_prio_idle", int'(busy), 0);

    run_one("after_abort", 16'h003E, 4'd5, 1'b0, 16'h0, 0, 0, 1, 8, 0);

    // Randomized runs against the reference
    for (int r = 0; r < 24; r++) begin
      rp  = 16'($urandom);
      rl  = 4'($urandom_range(0, 15));
      ryz = ($urandom_range(0, 5) == 0);
      rm  = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
      model(rp, int'(rl), ryz, rm, e_err, e_first, e_cyc);
      run_one($sformatf("rand%0d", r), rp, rl, ryz, rm, e_err, e_first,
              (e_err == 0) ? 1 : 0, e_cyc, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
